// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detects peripheral requests, masks and
// prioritises them (index 0 highest), and presents one interrupt at a time
// to the core as a registered Int pulse plus a stable 16-bit vector.
// A new interrupt is only started after the core reports RTI completion.
module interrupt_controller #(
  parameter int N_SRC     = 8,
  parameter int INT_PULSE = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_SRC-1:0] Req,
  input  logic             Mask_We,
  input  logic [N_SRC-1:0] Mask_In,
  input  logic             Rti_Done,
  output logic             Int,
  output logic [15:0]      Vector,
  output logic [N_SRC-1:0] Pending,
  output logic             Busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [N_SRC-1:0]   prev_req_reg;
  logic [N_SRC-1:0]   pending_reg, pending_next;
  logic [N_SRC-1:0]   mask_reg;
  logic [3:0]         id_reg, id_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic               int_reg, int_next;

  logic [N_SRC-1:0]   edge_vec;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   clear_vec;
  logic [3:0]         winner;
  logic               any_eligible;
  logic               take;

  assign edge_vec     = Req & ~prev_req_reg;
  assign eligible     = pending_reg & mask_reg;
  assign any_eligible = |eligible;
  // An interrupt is accepted only from IDLE; this is also when the winner's
  // pending bit is consumed.
  assign take         = (state_reg == S_IDLE) && any_eligible;

  // Fixed priority: scan from the top so the lowest eligible index wins.
  always_comb begin
    winner = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 4'(i);
      end
    end
  end

  // Per-source pending update; a coincident edge wins over the clear so a
  // fresh request is never lost.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pending
      assign clear_vec[gi]    = take && (winner == 4'(gi));
      assign pending_next[gi] = (pending_reg[gi] & ~clear_vec[gi]) | edge_vec[gi];
    end
  endgenerate

  // Next-state and registered-output logic for the service FSM.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    id_next    = id_reg;
    int_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (any_eligible) begin
          state_next = S_ASSERT;
          cnt_next   = 4'(INT_PULSE);
          id_next    = winner;
          int_next   = 1'b1;
        end
      end
      S_ASSERT: begin
        if (cnt_reg == 4'd1) begin
          state_next = S_WAIT;
          int_next   = 1'b0;
        end else begin
          cnt_next = 4'(cnt_reg - 4'd1);
          int_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (Rti_Done) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, request history, pending, mask and output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg    <= S_IDLE;
      prev_req_reg <= '0;
      pending_reg  <= '0;
      mask_reg     <= '1;
      id_reg       <= 4'd0;
      cnt_reg      <= 4'd0;
      int_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      prev_req_reg <= Req;
      pending_reg  <= pending_next;
      if (Mask_We) begin
        mask_reg <= Mask_In;
      end
      id_reg       <= id_next;
      cnt_reg      <= cnt_next;
      int_reg      <= int_next;
    end
  end

  assign Int     = int_reg;
  assign Vector  = 16'(id_reg);
  assign Pending = pending_reg;
  assign Busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller. Two instances share the
// clock and reset: one with a single-cycle Int pulse, one with a
// three-cycle pulse.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  req;
  logic        mask_we;
  logic [7:0]  mask_in;
  logic        rti;
  logic        int1;
  logic [15:0] vec1;
  logic [7:0]  pend1;
  logic        busy1;

  logic [7:0]  req3;
  logic        mask_we3;
  logic [7:0]  mask_in3;
  logic        rti3;
  logic        int3;
  logic [15:0] vec3;
  logic [7:0]  pend3;
  logic        busy3;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  interrupt_controller #(.N_SRC(8), .INT_PULSE(1)) dut1 (
    .Clk(clk), .Rst(rst), .Req(req), .Mask_We(mask_we), .Mask_In(mask_in),
    .Rti_Done(rti), .Int(int1), .Vector(vec1), .Pending(pend1), .Busy(busy1)
  );

  interrupt_controller #(.N_SRC(8), .INT_PULSE(3)) dut3 (
    .Clk(clk), .Rst(rst), .Req(req3), .Mask_We(mask_we3), .Mask_In(mask_in3),
    .Rti_Done(rti3), .Int(int3), .Vector(vec3), .Pending(pend3), .Busy(busy3)
  );

  // Count one comparison and report it if the observed value is wrong.
  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; mask_we = 1'b0; mask_in = '1; rti = 1'b0;
    req3 = '0; mask_we3 = 1'b0; mask_in3 = '1; rti3 = 1'b0;

    // Reset state
    tick(); tick();
    check_val("rst_int",  16'(int1),  16'h0);
    check_val("rst_vec",  vec1,       16'h0);
    check_val("rst_busy", 16'(busy1), 16'h0);
    check_val("rst_pend", 16'(pend1), 16'h0);
    $display("reset: outputs checked");

    // Test 1: single request on source 3
    rst = 1'b0; req = 8'h08;
    tick();
    check_val("t1_pend", 16'(pend1), 16'h08);
    check_val("t1_int_early", 16'(int1), 16'h0);
    tick();
    check_val("t1_int",  16'(int1),  16'h1);
    check_val("t1_vec",  vec1,       16'h3);
    check_val("t1_pclr", 16'(pend1), 16'h00);
    check_val("t1_busy", 16'(busy1), 16'h1);
    tick();
    check_val("t1_int_low", 16'(int1), 16'h0);
    check_val("t1_busy_w",  16'(busy1), 16'h1);
    check_val("t1_vec_hold", vec1, 16'h3);
    req = 8'h00;
    tick();
    check_val("t1_still_wait", 16'(busy1), 16'h1);
    rti = 1'b1;
    tick();
    rti = 1'b0;
    check_val("t1_idle", 16'(busy1), 16'h0);
    check_val("t1_vec_idle", vec1, 16'h3);
    $display("test1: req[3] serviced, vector 0x0003");

    // Test 2: simultaneous requests on sources 5 and 2
    req = 8'h24;
    tick();
    check_val("t2_pend", 16'(pend1), 16'h24);
    tick();
    check_val("t2_int_a", 16'(int1), 16'h1);
    check_val("t2_vec_a", vec1, 16'h2);
    check_val("t2_pend_a", 16'(pend1), 16'h20);
    tick();
    check_val("t2_wait_pend", 16'(pend1), 16'h20);
    check_val("t2_wait_int", 16'(int1), 16'h0);
    rti = 1'b1;
    tick();
    rti = 1'b0;
    check_val("t2_rti_int", 16'(int1), 16'h0);
    tick();
    check_val("t2_int_b", 16'(int1), 16'h1);
    check_val("t2_vec_b", vec1, 16'h5);
    check_val("t2_pend_b", 16'(pend1), 16'h00);
    req = 8'h00;
    tick();
    rti = 1'b1;
    tick();
    rti = 1'b0;
    check_val("t2_idle", 16'(busy1), 16'h0);
    $display("test2: vectors 0x0002 then 0x0005");

    // Test 3: masked source latches but is not serviced until unmasked
    mask_we = 1'b1; mask_in = 8'hFE;
    tick();
    mask_we = 1'b0; req = 8'h01;
    tick();
    check_val("t3_pend", 16'(pend1), 16'h01);
    tick();
    check_val("t3_masked_int", 16'(int1), 16'h0);
    check_val("t3_masked_busy", 16'(busy1), 16'h0);
    mask_we = 1'b1; mask_in = 8'hFF;
    tick();
    mask_we = 1'b0;
    check_val("t3_oldmask_int", 16'(int1), 16'h0);
    tick();
    check_val("t3_int", 16'(int1), 16'h1);
    check_val("t3_vec", vec1, 16'h0);
    check_val("t3_pclr", 16'(pend1), 16'h00);
    req = 8'h00;
    tick();
    rti = 1'b1;
    tick();
    rti = 1'b0;
    $display("test3: masked req[0] serviced after unmask");

    // Test 4: three-cycle pulse, held request, re-edge during WAIT
    req3 = 8'h80;
    tick();
    check_val("t4_pend", 16'(pend3), 16'h80);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("t4_int_hi", 16'(int3), 16'h1);
      check_val("t4_vec", vec3, 16'h7);
    end
    tick();
    check_val("t4_int_lo", 16'(int3), 16'h0);
    check_val("t4_busy", 16'(busy3), 16'h1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_val("t4_held_int", 16'(int3), 16'h0);
    end
    check_val("t4_held_pend", 16'(pend3), 16'h00);
    req3 = 8'h00;
    tick();
    req3 = 8'h80;
    tick();
    check_val("t4_re_pend", 16'(pend3), 16'h80);
    tick();
    check_val("t4_re_noint", 16'(int3), 16'h0);
    rti3 = 1'b1;
    tick();
    rti3 = 1'b0;
    check_val("t4_rti_idle", 16'(busy3), 16'h0);
    tick();
    check_val("t4_int2", 16'(int3), 16'h1);
    check_val("t4_vec2", vec3, 16'h7);
    req3 = 8'h00;
    $display("test4: one 3-cycle interrupt per req[7] edge");

    // Test 5: Rti_Done in ASSERT ignored, reset from WAIT
    req = 8'h40;
    tick();
    tick();
    check_val("t5_int", 16'(int1), 16'h1);
    check_val("t5_vec", vec1, 16'h6);
    rti = 1'b1;
    tick();
    rti = 1'b0;
    check_val("t5_wait_busy", 16'(busy1), 16'h1);
    tick();
    check_val("t5_wait_busy2", 16'(busy1), 16'h1);
    req = 8'h50;
    tick();
    check_val("t5_pend", 16'(pend1), 16'h10);
    rst = 1'b1;
    tick();
    check_val("t5_rst_int", 16'(int1), 16'h0);
    check_val("t5_rst_busy", 16'(busy1), 16'h0);
    check_val("t5_rst_pend", 16'(pend1), 16'h00);
    check_val("t5_rst_vec", vec1, 16'h0);
    $display("test5: reset in WAIT clears controller");

    // Test 6: request already high across reset release counts as an edge
    req = 8'h02;
    tick();
    check_val("t6_in_rst_pend", 16'(pend1), 16'h00);
    rst = 1'b0;
    tick();
    check_val("t6_pend", 16'(pend1), 16'h02);
    check_val("t6_int_early", 16'(int1), 16'h0);
    tick();
    check_val("t6_int", 16'(int1), 16'h1);
    check_val("t6_vec", vec1, 16'h1);
    $display("test6: req[1] high at reset release serviced");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
